// File: rtl/seg_scan_pkg.sv
// Shared constants, types and helpers for the seg_scan_mux display scanner.
// Also used by seg_scan_mux_if and the leading-zero blank build (SEG_SCAN_LEADING_ZERO_BLANK_EN).
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

  typedef logic [IDX_W-1:0] digit_idx_t;

  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dig_en;
    logic [NUM_DIGITS-1:0] dp_en;
  } disp_t;

  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [VALUE_W-1:0] value,
                                                    input digit_idx_t idx);
    return value[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

  // Digits at or below the most significant nonzero nibble stay visible; digit 0 always does.
  function automatic logic [NUM_DIGITS-1:0] lz_keep(input logic [VALUE_W-1:0] value);
    logic [NUM_DIGITS-1:0] keep;
    logic                  above;
    keep  = '0;
    above = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above   = above | (value[i*NIBBLE_W +: NIBBLE_W] != '0);
      keep[i] = above;
    end
    keep[0] = 1'b1;
    return keep;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle of seg_scan_mux: load port in, decoder nibble and anode drive out.
interface seg_scan_mux_if;

  logic [seg_scan_pkg::VALUE_W-1:0]    VALUE;
  logic [seg_scan_pkg::NUM_DIGITS-1:0] DIG_EN;
  logic [seg_scan_pkg::NUM_DIGITS-1:0] DP_EN;
  logic                                LOAD;
  logic [seg_scan_pkg::NIBBLE_W-1:0]   D;
  logic [seg_scan_pkg::NUM_DIGITS-1:0] AN;
  logic                                DP;
  logic                                FRAME;

  modport master (output VALUE, DIG_EN, DP_EN, LOAD, input D, AN, DP, FRAME);
  modport slave  (input VALUE, DIG_EN, DP_EN, LOAD, output D, AN, DP, FRAME);

endinterface

// File: rtl/seg_scan_prescaler.sv
// Digit-slot prescaler: free-running 0..PRESCALE-1 counter, tick on the last count.
module seg_scan_prescaler #(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(PRESCALE - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// 8-digit 7-segment scanner with tear-free frame update and anode dead time.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE    = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic           CLK,
  input  logic           RST,
  seg_scan_mux_if.slave  bus
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  logic                  tick;
  logic                  wrap;
  digit_idx_t            idx_q;
  digit_idx_t            idx_next;
  logic [DEAD_W-1:0]     dead_q;
  logic                  pending_q;
  disp_t                 hold_q;
  disp_t                 shadow_q;
  disp_t                 shadow_next;
  disp_t                 load_data;
  logic [NUM_DIGITS-1:0] show;
  logic [NUM_DIGITS-1:0] an_on;
  logic                  dp_on;
  logic [NIBBLE_W-1:0]   d_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  dp_q;
  logic                  frame_q;

  seg_scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (CLK),
    .rst  (RST),
    .tick (tick)
  );

  assign load_data = '{value: bus.VALUE, dig_en: bus.DIG_EN, dp_en: bus.DP_EN};
  assign wrap      = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign idx_next  = idx_q + 1'b1;

  // A LOAD landing on the wrap edge bypasses hold so digit 0 already shows it.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    shadow_next = shadow_q;
    if (wrap) begin
      if (bus.LOAD)      shadow_next = load_data;
      else if (pending_q) shadow_next = hold_q;
    end
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       blank_q <= lz_keep('0);
    else if (wrap) blank_q <= lz_keep(shadow_next.value);
  end

  assign show  = shadow_q.dig_en & blank_q;
  assign dp_on = ~(shadow_q.dp_en[idx_q] & blank_q[idx_q]);
`else
  assign show  = shadow_q.dig_en;
  assign dp_on = ~shadow_q.dp_en[idx_q];
`endif

  assign an_on = ~(show & (NUM_DIGITS'(1) << idx_q));

  // NOTE: the display registers are plain flops, not a memory, so all of them take reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q     <= '0;
      dead_q    <= DEAD_W'(DEAD_CYCLES);
      pending_q <= 1'b0;
      hold_q    <= '0;
      shadow_q  <= '0;
      d_q       <= '0;
      an_q      <= AN_ALL_OFF;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      frame_q  <= wrap;
      shadow_q <= shadow_next;

      if (bus.LOAD) hold_q <= load_data;
      if (wrap)          pending_q <= 1'b0;
      else if (bus.LOAD) pending_q <= 1'b1;

      // D moves with the tick; the anode follows DEAD_CYCLES+1 edges later.
      if (tick) begin
        idx_q  <= idx_next;
        d_q    <= nibble_of(shadow_next.value, idx_next);
        an_q   <= AN_ALL_OFF;
        dp_q   <= 1'b1;
        dead_q <= DEAD_W'(DEAD_CYCLES);
      end else if (dead_q != '0) begin
        dead_q <= dead_q - 1'b1;
      end else begin
        an_q <= an_on;
        dp_q <= dp_on;
      end
    end
  end

  assign bus.D     = d_q;
  assign bus.AN    = an_q;
  assign bus.DP    = dp_q;
  assign bus.FRAME = frame_q;

endmodule
